vga_write_arbiter: RTL

- Shares the single pixel-write port of the VGA adapter among NREQ animated-object requesters.
- Each requester holds req high for a whole erase/move/draw cycle.
- The arbiter grants one requester at a time, round-robin, and muxes that requester's x/y/color/write onto the adapter port.
- Replaces the hard-coded two-object fixed-priority FSM at top level, so more objects can be added without starvation.

---
 rtl/vga_arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 36 +++
 rtl/vga_write_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vga_arb_pkg.sv
// Shared types and helpers for the VGA pixel-write arbiter.
// Optional forced-revoke timeout is enabled by defining ARB_TIMEOUT_EN.
package vga_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int NX_DEF = 10;
    localparam int NY_DEF = 9;
    localparam int CW_DEF = 9;

    // Never returns less than 1 so index ports always have a legal width.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping modulo NREQ, found by scanning a rotated double-width copy.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   index
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int                sum;

    always_comb begin
        dbl   = {req, req};
        rot   = NREQ'(dbl >> ptr);
        valid = 1'b0;
        index = '0;
        sum   = 0;
        // Descending scan so the lowest rotated position wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                index = IW'(sum);
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the VGA adapter pixel-write port among NREQ objects.
// Define ARB_TIMEOUT_EN to revoke grants held for MAX_HOLD cycles.
module vga_write_arbiter
    import vga_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int nX       = NX_DEF,
    parameter int nY       = NY_DEF,
    parameter int CW       = CW_DEF,
    parameter int MAX_HOLD = 4096
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [NREQ-1:0]        req,
    output logic [NREQ-1:0]        gnt,
    input  logic [NREQ*nX-1:0]     obj_x,
    input  logic [NREQ*nY-1:0]     obj_y,
    input  logic [NREQ*CW-1:0]     obj_color,
    input  logic [NREQ-1:0]        obj_write,
    output logic [nX-1:0]          VGA_x,
    output logic [nY-1:0]          VGA_y,
    output logic [CW-1:0]          VGA_color,
    output logic                   VGA_write,
    output logic [clog2(NREQ)-1:0] owner,
    output logic                   busy,
    output logic                   timeout
);

    localparam int IW = clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            timeout_q, timeout_d;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   owner_next;
    logic            revoke;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign owner_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = clog2(MAX_HOLD);
    logic [HW-1:0] hold_q, hold_d;

    assign hold_d = (state_q == ARB_GRANT) ? hold_q + 1'b1 : '0;
    assign revoke = (state_q == ARB_GRANT) && (hold_q == HW'(MAX_HOLD - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD == 0);
    assign revoke          = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_GRANT;
                    owner_d = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                end
            end
            ARB_GRANT: begin
                // Release and timeout both hand priority to the next index.
                if (!req[owner_q] || revoke) begin
                    state_d   = ARB_IDLE;
                    gnt_d     = '0;
                    ptr_d     = owner_next;
                    timeout_d = req[owner_q] && revoke;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign busy      = (state_q == ARB_GRANT);
    assign timeout   = timeout_q;
    assign VGA_x     = obj_x[owner_q*nX +: nX];
    assign VGA_y     = obj_y[owner_q*nY +: nY];
    assign VGA_color = obj_color[owner_q*CW +: CW];
    // A grant being aborted by reset must not leak a pixel write.
    assign VGA_write = busy & ~Reset & req[owner_q] & obj_write[owner_q];

endmodule
